timestamp_unit: RTL and testbench

TIMESTAMP_UNIT -- requirements
Module: timestamp_unit

---
 rtl/timestamp_unit.sv | 117 +++++++++++
 tb/tb_timestamp_unit.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/timestamp_unit.sv
// timestamp_unit: free-running time counter with prescaler, short-time wrap
// pulse, and NCH independent capture channels using a valid/ready handshake.
//
// Ports:
//   clk       - sole clock, all state updates on posedge
//   rst_n     - synchronous active-low reset
//   en        - prescaler/counter advance enable
//   load      - load counter from load_val (overrides en and tick)
//   load_val  - WIDTH-bit load value
//   trig      - per-channel capture request
//   ts_ready  - per-channel consumer ready
//   ovf_clr   - per-channel overflow flag clear
//   now       - current time counter
//   now_short - low SWIDTH bits of now (combinational)
//   swrap     - one-cycle pulse when an increment wraps now_short to zero
//   ts_valid  - per-channel timestamp held
//   ts_long   - captured timestamps, channel i at [i*WIDTH +: WIDTH]
//   ts_short  - low SWIDTH bits of each captured timestamp
//   ovf       - sticky per-channel dropped-capture flag
module timestamp_unit #(
    parameter int unsigned WIDTH    = 64,
    parameter int unsigned SWIDTH   = 32,
    parameter int unsigned NCH      = 4,
    parameter int unsigned PRESCALE = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    load,
    input  logic [WIDTH-1:0]        load_val,
    input  logic [NCH-1:0]          trig,
    input  logic [NCH-1:0]          ts_ready,
    input  logic [NCH-1:0]          ovf_clr,
    output logic [WIDTH-1:0]        now,
    output logic [SWIDTH-1:0]       now_short,
    output logic                    swrap,
    output logic [NCH-1:0]          ts_valid,
    output logic [NCH*WIDTH-1:0]    ts_long,
    output logic [NCH*SWIDTH-1:0]   ts_short,
    output logic [NCH-1:0]          ovf
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

    logic [PW-1:0]  pcnt;
    logic           tick;
    logic [NCH-1:0] accept;
    logic [NCH-1:0] drop;
    logic [NCH-1:0] valid_nxt;
    logic [NCH-1:0] ovf_nxt;

    // Tick fires on the last enabled cycle of each prescale period.
    assign tick      = en && (pcnt == PMAX);
    assign now_short = now[SWIDTH-1:0];

    // Prescaler: load restarts the period, en=0 freezes it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pcnt <= '0;
        end else if (load) begin
            pcnt <= '0;
        end else if (en) begin
            pcnt <= tick ? '0 : pcnt + PW'(1);
        end
    end

    // Time counter and short-wrap pulse; a load never produces swrap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            now   <= '0;
            swrap <= 1'b0;
        end else begin
            swrap <= tick && !load && (&now[SWIDTH-1:0]);
            if (load) begin
                now <= load_val;
            end else if (tick) begin
                now <= now + WIDTH'(1);
            end
        end
    end

    // Channel handshake: accept into an empty slot or one draining this cycle.
    always_comb begin
        accept    = '0;
        drop      = '0;
        valid_nxt = '0;
        ovf_nxt   = '0;
        accept    = trig & (~ts_valid | ts_ready);
        drop      = trig & ts_valid & ~ts_ready;
        valid_nxt = accept | (ts_valid & ~ts_ready);
        // Set has priority over clear so a drop is never lost.
        ovf_nxt   = drop | (ovf & ~ovf_clr);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ts_valid <= '0;
            ovf      <= '0;
            ts_long  <= '0;
        end else begin
            ts_valid <= valid_nxt;
            ovf      <= ovf_nxt;
            for (int i = 0; i < int'(NCH); i++) begin
                if (accept[i]) begin
                    ts_long[i*WIDTH +: WIDTH] <= now;
                end
            end
        end
    end

    // Short timestamps are a view of the captured long values.
    for (genvar g = 0; g < int'(NCH); g++) begin : g_short
        assign ts_short[g*SWIDTH +: SWIDTH] = ts_long[g*WIDTH +: SWIDTH];
    end

endmodule

// File: tb/tb_timestamp_unit.sv
// Directed testbench for timestamp_unit: one DUT with PRESCALE=1 for the main
// features and one with PRESCALE=3 for the prescaler.
module tb_timestamp_unit;

    localparam int unsigned W  = 64;
    localparam int unsigned SW = 32;
    localparam int unsigned N  = 4;

    logic            clk;
    logic            rst_n;
    logic            en;
    logic            load;
    logic [W-1:0]    load_val;
    logic [N-1:0]    trig;
    logic [N-1:0]    ts_ready;
    logic [N-1:0]    ovf_clr;
    logic [W-1:0]    now;
    logic [SW-1:0]   now_short;
    logic            swrap;
    logic [N-1:0]    ts_valid;
    logic [N*W-1:0]  ts_long;
    logic [N*SW-1:0] ts_short;
    logic [N-1:0]    ovf;

    logic            en3;
    logic [W-1:0]    now3;
    logic [SW-1:0]   now_short3;
    logic            swrap3;
    logic [N-1:0]    ts_valid3;
    logic [N*W-1:0]  ts_long3;
    logic [N*SW-1:0] ts_short3;
    logic [N-1:0]    ovf3;

    int nvec;
    int nerr;

    timestamp_unit #(.WIDTH(W), .SWIDTH(SW), .NCH(N), .PRESCALE(1)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .load(load), .load_val(load_val),
        .trig(trig), .ts_ready(ts_ready), .ovf_clr(ovf_clr),
        .now(now), .now_short(now_short), .swrap(swrap), .ts_valid(ts_valid),
        .ts_long(ts_long), .ts_short(ts_short), .ovf(ovf)
    );

    timestamp_unit #(.WIDTH(W), .SWIDTH(SW), .NCH(N), .PRESCALE(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .en(en3), .load(1'b0), .load_val(load_val),
        .trig(trig), .ts_ready(ts_ready), .ovf_clr(ovf_clr),
        .now(now3), .now_short(now_short3), .swrap(swrap3), .ts_valid(ts_valid3),
        .ts_long(ts_long3), .ts_short(ts_short3), .ovf(ovf3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; en = 1'b0; en3 = 1'b0; load = 1'b0; load_val = '0;
        trig = '0; ts_ready = '0; ovf_clr = '0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        // Reset must override load, trig and ovf_clr.
        rst_n = 1'b0; en = 1'b1; en3 = 1'b1; load = 1'b1; load_val = 64'd123;
        trig = '1; ts_ready = '0; ovf_clr = '1;
        step();
        step();
        nvec++; if (now !== 64'd0) begin nerr++; $display("FAIL reset_now: got %h want 0", now); end
        nvec++; if (swrap !== 1'b0) begin nerr++; $display("FAIL reset_swrap: got %b want 0", swrap); end
        nvec++; if (ts_valid !== 4'h0) begin nerr++; $display("FAIL reset_valid: got %h want 0", ts_valid); end
        nvec++; if (ts_long !== '0) begin nerr++; $display("FAIL reset_ts_long: got %h want 0", ts_long); end
        nvec++; if (ts_short !== '0) begin nerr++; $display("FAIL reset_ts_short: got %h want 0", ts_short); end
        nvec++; if (ovf !== 4'h0) begin nerr++; $display("FAIL reset_ovf: got %h want 0", ovf); end
        nvec++; if ({now3, now_short3, swrap3, ts_valid3, ts_long3, ts_short3, ovf3} !== '0) begin
            nerr++; $display("FAIL reset_dut3: got now3=%h valid3=%h ovf3=%h want all zero", now3, ts_valid3, ovf3);
        end
        rst_n = 1'b1; en = 1'b0; en3 = 1'b0; load = 1'b0; trig = '0; ovf_clr = '0;
        step();
        nvec++; if (now !== 64'd0) begin nerr++; $display("FAIL reset_hold_now: got %h want 0", now); end
    endtask

    task automatic test_count();
        do_reset();
        en = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            step();
            nvec++; if (now !== 64'(k)) begin nerr++; $display("FAIL count_now k=%0d: got %h want %h", k, now, 64'(k)); end
            nvec++; if (now_short !== now[31:0]) begin nerr++; $display("FAIL count_short k=%0d: got %h want %h", k, now_short, now[31:0]); end
        end
        en = 1'b0;
        step();
        nvec++; if (now !== 64'd100) begin nerr++; $display("FAIL count_freeze: got %h want 100", now); end
    endtask

    task automatic test_prescale();
        do_reset();
        en3 = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            step();
            nvec++; if (now3 !== 64'(k / 3)) begin nerr++; $display("FAIL prescale_now k=%0d: got %h want %h", k, now3, 64'(k / 3)); end
        end
        en3 = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            nvec++; if (now3 !== 64'd3) begin nerr++; $display("FAIL prescale_hold k=%0d: got %h want 3", k, now3); end
        end
    endtask

    task automatic test_short_wrap();
        do_reset();
        load = 1'b1; load_val = 64'h0000_0000_FFFF_FFFE;
        step();
        load = 1'b0; en = 1'b1;
        nvec++; if (now !== 64'h0000_0000_FFFF_FFFE) begin nerr++; $display("FAIL swrap_load: got %h want FFFFFFFE", now); end
        step();
        nvec++; if (now_short !== 32'hFFFF_FFFF || swrap !== 1'b0) begin
            nerr++; $display("FAIL swrap_pre: got short=%h swrap=%b want FFFFFFFF/0", now_short, swrap);
        end
        step();
        nvec++; if (now_short !== 32'h0 || swrap !== 1'b1 || now !== 64'h1_0000_0000) begin
            nerr++; $display("FAIL swrap_wrap: got now=%h swrap=%b want 100000000/1", now, swrap);
        end
        step();
        nvec++; if (swrap !== 1'b0 || now !== 64'h1_0000_0001) begin
            nerr++; $display("FAIL swrap_post: got now=%h swrap=%b want 100000001/0", now, swrap);
        end
        // A load from short all-ones to zero, even with en=1, gives no pulse.
        en = 1'b0; load = 1'b1; load_val = 64'h0000_0000_FFFF_FFFF;
        step();
        en = 1'b1; load_val = 64'd0;
        step();
        load = 1'b0; en = 1'b0;
        nvec++; if (swrap !== 1'b0 || now !== 64'd0) begin
            nerr++; $display("FAIL swrap_load_nopulse: got now=%h swrap=%b want 0/0", now, swrap);
        end
    endtask

    task automatic test_long_wrap();
        do_reset();
        load = 1'b1; load_val = '1;
        step();
        load = 1'b0; en = 1'b1; trig = 4'b0010;
        step();
        en = 1'b0; trig = '0;
        nvec++; if (now !== 64'd0) begin nerr++; $display("FAIL lwrap_now: got %h want 0", now); end
        nvec++; if (ts_valid !== 4'b0010) begin nerr++; $display("FAIL lwrap_valid: got %b want 0010", ts_valid); end
        nvec++; if (ts_long[1*W +: W] !== {W{1'b1}}) begin nerr++; $display("FAIL lwrap_ts: got %h want all-ones", ts_long[1*W +: W]); end
        nvec++; if (ts_short[1*SW +: SW] !== 32'hFFFF_FFFF) begin nerr++; $display("FAIL lwrap_short: got %h want FFFFFFFF", ts_short[1*SW +: SW]); end
        ts_ready = 4'b0010;
        step();
        ts_ready = '0;
        nvec++; if (ts_valid !== 4'b0000 || ts_long[1*W +: W] !== {W{1'b1}}) begin
            nerr++; $display("FAIL lwrap_drain: got valid=%b ts=%h want 0000/all-ones", ts_valid, ts_long[1*W +: W]);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        load = 1'b1; load_val = 64'd5;
        step();
        load = 1'b0; trig = 4'b0001;
        step();
        trig = '0;
        nvec++; if (ts_valid !== 4'b0001 || ts_long[W-1:0] !== 64'd5) begin
            nerr++; $display("FAIL ovf_first: got valid=%b ts=%h want 0001/5", ts_valid, ts_long[W-1:0]);
        end
        load = 1'b1; load_val = 64'd8;
        step();
        load = 1'b0; trig = 4'b0001;
        step();
        trig = '0;
        nvec++; if (ovf !== 4'b0001 || ts_long[W-1:0] !== 64'd5 || ts_valid !== 4'b0001) begin
            nerr++; $display("FAIL ovf_drop: got ovf=%b ts=%h valid=%b want 0001/5/0001", ovf, ts_long[W-1:0], ts_valid);
        end
        ts_ready = 4'b0001;
        step();
        ts_ready = '0;
        nvec++; if (ts_valid !== 4'b0000 || ovf !== 4'b0001 || ts_long[W-1:0] !== 64'd5) begin
            nerr++; $display("FAIL ovf_drain: got valid=%b ovf=%b ts=%h want 0000/0001/5", ts_valid, ovf, ts_long[W-1:0]);
        end
        ovf_clr = 4'b0001;
        step();
        ovf_clr = '0;
        nvec++; if (ovf !== 4'b0000) begin nerr++; $display("FAIL ovf_clear: got %b want 0000", ovf); end
        // Fresh capture of 8, then a drop with simultaneous clear keeps ovf set.
        trig = 4'b0001;
        step();
        ovf_clr = 4'b0001;
        step();
        trig = '0;
        nvec++; if (ovf !== 4'b0001 || ts_long[W-1:0] !== 64'd8) begin
            nerr++; $display("FAIL ovf_set_wins: got ovf=%b ts=%h want 0001/8", ovf, ts_long[W-1:0]);
        end
        step();
        ovf_clr = '0;
        nvec++; if (ovf !== 4'b0000 || ts_valid !== 4'b0001) begin
            nerr++; $display("FAIL ovf_clr2: got ovf=%b valid=%b want 0000/0001", ovf, ts_valid);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        load = 1'b1; load_val = 64'd42;
        step();
        load = 1'b0; en = 1'b1; trig = '1; ts_ready = '1;
        step();
        nvec++; if (now !== 64'd43 || ts_valid !== 4'hF) begin
            nerr++; $display("FAIL b2b_first: got now=%h valid=%h want 43/F", now, ts_valid);
        end
        for (int i = 0; i < int'(N); i++) begin
            nvec++; if (ts_long[i*W +: W] !== 64'd42 || ts_short[i*SW +: SW] !== 32'd42) begin
                nerr++; $display("FAIL b2b_42 ch%0d: got %h want 42", i, ts_long[i*W +: W]);
            end
        end
        en = 1'b0;
        step();
        trig = '0;
        for (int i = 0; i < int'(N); i++) begin
            nvec++; if (ts_long[i*W +: W] !== 64'd43) begin
                nerr++; $display("FAIL b2b_43 ch%0d: got %h want 43", i, ts_long[i*W +: W]);
            end
        end
        nvec++; if (ovf !== 4'h0 || ts_valid !== 4'hF) begin
            nerr++; $display("FAIL b2b_flags: got ovf=%h valid=%h want 0/F", ovf, ts_valid);
        end
        step();
        ts_ready = '0;
        nvec++; if (ts_valid !== 4'h0 || ts_long[3*W +: W] !== 64'd43) begin
            nerr++; $display("FAIL b2b_drain: got valid=%h ts3=%h want 0/43", ts_valid, ts_long[3*W +: W]);
        end
    endtask

    task automatic test_reset_midhandshake();
        do_reset();
        load = 1'b1; load_val = 64'd77;
        step();
        load = 1'b0; trig = 4'b0001;
        step();
        trig = '0;
        nvec++; if (ts_valid !== 4'b0001 || ts_long[W-1:0] !== 64'd77) begin
            nerr++; $display("FAIL mid_capture: got valid=%b ts=%h want 0001/77", ts_valid, ts_long[W-1:0]);
        end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        nvec++; if (ts_valid !== 4'b0000 || ts_long !== '0 || now !== 64'd0) begin
            nerr++; $display("FAIL mid_reset: got valid=%b ts0=%h now=%h want 0/0/0", ts_valid, ts_long[W-1:0], now);
        end
        trig = 4'b1000;
        step();
        trig = '0;
        nvec++; if (ts_valid !== 4'b1000 || ts_long[3*W +: W] !== 64'd0) begin
            nerr++; $display("FAIL mid_first_trig: got valid=%b ts3=%h want 1000/0", ts_valid, ts_long[3*W +: W]);
        end
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        test_reset();
        test_count();
        test_prescale();
        test_short_wrap();
        test_long_wrap();
        test_overflow();
        test_back_to_back();
        test_reset_midhandshake();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
